// File: rtl/ram_rd_stream.sv
// Burst reader: streams len consecutive RAM words from base (wrapping at ARR_DEPTH)
// onto a valid/ready interface, with a 2-entry skid FIFO absorbing RAM read latency.
module ram_rd_stream #(
    parameter int VEC_WIDTH  = 264,
    parameter int ARR_DEPTH  = 2048,
    parameter int ADDR_WIDTH = $clog2(ARR_DEPTH),
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    input  logic [VEC_WIDTH-1:0]  i_ram_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [VEC_WIDTH-1:0]  o_data,
    output logic                  o_last
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
    logic                   pend_q, pend_d;
    logic                   pend_last_q, pend_last_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic [VEC_WIDTH-1:0]   data0_q, data0_d, data1_q, data1_d;
    logic                   last0_q, last0_d, last1_q, last1_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   pop;
    logic                   issue;
    logic [2:0]             occ;
    logic [1:0]             wr_idx;

    always_comb begin
        pop   = valid_q && i_ready;
        // Occupancy the FIFO will have once this cycle's capture and pop settle.
        occ   = 3'(cnt_q) + 3'(pend_q) - 3'(pop);
        issue = (state_q == ISSUE) && (remaining_q != '0) && (occ < 3'd2);

        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    addr_d      = i_base_addr;
                    remaining_d = i_len;
                    state_d     = (i_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d      = (addr_q == ADDR_WIDTH'(ARR_DEPTH - 1)) ? '0
                                                                          : addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1))
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && last0_q)
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        pend_d      = issue;
        pend_last_d = issue && (remaining_q == LEN_WIDTH'(1));

        // Head is always slot 0; a pop shifts slot 1 down and clears its last tag
        // so a stale tag can never surface once the entry is gone.
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        if (pop) begin
            data0_d = data1_q;
            last0_d = last1_q;
            last1_d = 1'b0;
        end
        wr_idx = cnt_q - 2'(pop);
        if (pend_q) begin
            if (wr_idx == 2'd0) begin
                data0_d = i_ram_data;
                last0_d = pend_last_q;
            end else begin
                data1_d = i_ram_data;
                last1_d = pend_last_q;
            end
        end

        cnt_d   = cnt_q + 2'(pend_q) - 2'(pop);
        valid_d = (cnt_d != 2'd0);
        busy_d  = (state_d == ISSUE) || (state_d == DRAIN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            cnt_q       <= 2'd0;
            valid_q     <= 1'b0;
            data0_q     <= '0;
            data1_q     <= '0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_ram_we   = 1'b0;
    assign o_ram_addr = addr_q;
    assign o_valid    = valid_q;
    assign o_data     = data0_q;
    assign o_last     = last0_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_ram_rd_stream.sv
// Randomized self-checking bench for ram_rd_stream: a queue-based burst model
// predicts every beat from the RAM image, base and length.
module tb_ram_rd_stream;

    localparam int VW    = 264;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;
    localparam int LW    = 12;

    logic           clk = 1'b0;
    logic           i_rst_n;
    logic           i_start;
    logic [AW-1:0]  i_base_addr;
    logic [LW-1:0]  i_len;
    logic           o_busy;
    logic           o_done;
    logic           o_ram_we;
    logic [AW-1:0]  o_ram_addr;
    logic [VW-1:0]  ram_q;
    logic           o_valid;
    logic           i_ready;
    logic [VW-1:0]  o_data;
    logic           o_last;

    always #5 clk = ~clk;

    ram_rd_stream dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_ram_we    (o_ram_we),
        .o_ram_addr  (o_ram_addr),
        .i_ram_data  (ram_q),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_last      (o_last)
    );

    logic [VW-1:0] mem [DEPTH];
    always @(posedge clk) ram_q <= mem[o_ram_addr];

    typedef struct packed {
        logic [VW-1:0] d;
        logic          l;
    } beat_t;
    beat_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_last"}, o_last, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_addr"}, o_ram_addr, 0);
        chk({tag, "_we"}, o_ram_we, 0);
    endtask

    // mode: 0 ready always high, 1 fixed stall pattern, 2 random ready.
    // alt_base >= 0 fires a second start during ISSUE; abort_beat >= 0 resets on that beat.
    task automatic run_burst(input int base, input int len, input int mode,
                             input int alt_base, input int abort_beat);
        int n, done_at, first_v, beats, bound, idx, post_valid;
        logic [0:5] pat;
        pat = 6'b100101;
        exp_q.delete();
        for (int i = 0; i < len; i++)
            exp_q.push_back('{d: mem[(base + i) % DEPTH], l: (i == len - 1)});

        i_start     = 1'b1;
        i_base_addr = AW'(base);
        i_len       = LW'(len);
        @(posedge clk);
        #1;
        i_start     = 1'b0;
        i_base_addr = AW'($urandom);
        i_len       = LW'($urandom);

        n = 0; done_at = -1; first_v = -1; beats = 0; bound = 4 * len + 20;
        while (done_at < 0 && n < bound) begin
            n++;
            case (mode)
                0: i_ready = 1'b1;
                1: begin
                    idx = n - 3;
                    i_ready = (idx >= 0 && idx < 6) ? pat[idx] : 1'b1;
                end
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
            if (alt_base >= 0 && n == 2) begin
                i_start     = 1'b1;
                i_base_addr = AW'(alt_base);
                i_len       = LW'(len + 3);
            end
            if (alt_base >= 0 && n == 3) i_start = 1'b0;

            @(negedge clk);
            if (abort_beat >= 0 && o_valid && beats == abort_beat) begin
                i_rst_n = 1'b0;
                #1;
                chk_reset_outputs("midrst");
                exp_q.delete();
                repeat (2) @(posedge clk);
                @(negedge clk);
                i_rst_n = 1'b1;
                post_valid = 0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    if (o_valid) post_valid++;
                end
                chk("post_rst_valid_cnt", post_valid, 0);
                chk("post_rst_busy", o_busy, 0);
                @(posedge clk);
                #1;
                return;
            end
            chk("we", o_ram_we, 0);
            if (o_valid) begin
                if (first_v < 0) first_v = n;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    chk("data", o_data, exp_q[0].d);
                    chk("last", o_last, exp_q[0].l);
                    if (i_ready) begin
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
            end
            if (o_done) begin
                done_at = n;
                chk("busy_at_done", o_busy, 0);
            end else begin
                chk("busy", o_busy, (len != 0));
            end
            @(posedge clk);
            #1;
        end

        chk("done_seen", (done_at >= 0), 1);
        chk("beats_left", exp_q.size(), 0);
        chk("beat_count", beats, len);
        if (mode == 0 && len > 0) begin
            chk("first_valid_cyc", first_v, 3);
            chk("done_cyc", done_at, len + 3);
        end
        if (len == 0) begin
            chk("zero_done_cyc", done_at, 1);
            chk("zero_no_valid", (first_v < 0), 1);
        end
        $display("burst base=%0d len=%0d mode=%0d beats=%0d done_at=%0d", base, len, mode, beats, done_at);
    endtask

    initial begin
        logic [VW-1:0] tmp;
        i_rst_n     = 1'b0;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_len       = '0;
        i_ready     = 1'b1;
        for (int k = 0; k < DEPTH; k++) mem[k] = VW'(k);

        @(negedge clk);
        chk_reset_outputs("rst");
        @(negedge clk);
        i_rst_n = 1'b1;

        run_burst(5, 4, 0, -1, -1);
        run_burst(2046, 4, 0, -1, -1);
        run_burst(10, 6, 1, -1, -1);
        run_burst(20, 0, 0, -1, -1);
        run_burst(30, 6, 0, 100, -1);
        run_burst(40, 8, 0, -1, 2);
        run_burst(0, 2, 0, -1, -1);

        for (int k = 0; k < DEPTH; k++) begin
            tmp = '0;
            for (int w = 0; w < 9; w++) tmp = {tmp[VW-33:0], 32'($urandom)};
            mem[k] = tmp;
        end
        run_burst(int'($urandom_range(0, DEPTH - 1)), DEPTH, 0, -1, -1);
        for (int t = 0; t < 25; t++)
            run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 24)),
                      int'($urandom_range(0, 2)), -1, -1);

        @(negedge clk);
        chk("tail_done", o_done, 0);
        chk("tail_busy", o_busy, 0);
        chk("tail_valid", o_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_rd_stream.md
RAM_RD_STREAM -- requirements
Module: ram_rd_stream

Interface
REQ-001 SHALL have parameter VEC_WIDTH, default 264, the RAM word width in bits.
REQ-002 SHALL have parameter ARR_DEPTH, default 2048, the RAM depth in words.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(ARR_DEPTH), the RAM address width.
REQ-004 SHALL have parameter LEN_WIDTH, default ADDR_WIDTH+1, the burst length width.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_start, input, 1, burst request, sampled only in IDLE.
REQ-008 SHALL have port i_base_addr, input, ADDR_WIDTH, first RAM word of the burst.
REQ-009 SHALL have port i_len, input, LEN_WIDTH, number of words to read (0..ARR_DEPTH).
REQ-010 SHALL have port o_busy, output, 1, high in ISSUE and DRAIN.
REQ-011 SHALL have port o_done, output, 1, one-cycle pulse on burst completion.
REQ-012 SHALL have port o_ram_we, output, 1, RAM write enable, constant 0.
REQ-013 SHALL have port o_ram_addr, output, ADDR_WIDTH, RAM address, driven from a register.
REQ-014 SHALL have port i_ram_data, input, VEC_WIDTH, RAM read data, valid one cycle after its address.
REQ-015 SHALL have port o_valid, output, 1, stream beat valid.
REQ-016 SHALL have port i_ready, input, 1, downstream ready; a beat transfers when o_valid and i_ready are both high.
REQ-017 SHALL have port o_data, output, VEC_WIDTH, stream beat data.
REQ-018 SHALL have port o_last, output, 1, high with the final beat of a burst.

Function
REQ-019 SHALL implement an FSM with states IDLE, ISSUE, DRAIN and DONE.
REQ-020 SHALL, in IDLE with i_start=1, latch i_base_addr and i_len, then go to ISSUE, or to DONE if i_len=0.
REQ-021 SHALL ignore i_start in ISSUE, DRAIN and DONE.
REQ-022 SHALL issue one read per cycle in ISSUE when issue = (remaining!=0) && (buf_cnt + pend - pop < 2), where pend = a read issued last cycle and pop = beat transferred this cycle.
REQ-023 SHALL capture i_ram_data into a 2-entry FIFO in the cycle after each issued read; captures are never dropped or duplicated.
REQ-024 SHALL hold o_ram_addr at the address of the next read; after each issue it increments modulo ARR_DEPTH (ARR_DEPTH-1 wraps to 0).
REQ-025 SHALL leave ISSUE for DRAIN after the last read is issued.
REQ-026 SHALL leave DRAIN for DONE on the cycle after the beat with o_last=1 transfers.
REQ-027 SHALL spend exactly one cycle in DONE with o_done=1 and o_busy=0, then return to IDLE.
REQ-028 SHALL present o_valid, o_data and o_last from the FIFO head.
REQ-029 SHALL hold o_data and o_last stable while o_valid=1 and i_ready=0.
REQ-030 SHALL set o_last=1 only on beat number len-1 (0-based).
REQ-031 SHALL meet this latency: with i_start sampled at edge E0, address = base is issued in the cycle after E0, and o_valid first rises after E2.
REQ-032 SHALL sustain 1 beat per cycle while i_ready=1.
REQ-033 SHALL resume without loss, reorder or gap when i_ready toggles arbitrarily.
REQ-034 SHALL accept i_len=ARR_DEPTH, reading every word once starting at base and wrapping.
REQ-035 SHALL accept a new i_start in the IDLE cycle right after DONE.

Reset
REQ-036 SHALL, while i_rst_n=0, immediately force state=IDLE, FIFO empty, pend=0, o_ram_addr=0, o_valid=0, o_last=0, o_data=0, o_busy=0, o_done=0 and o_ram_we=0.
REQ-037 SHALL discard any in-flight burst on reset asserted mid-burst; no beats appear after release until a new i_start.
REQ-038 SHALL make i_start sampled at the first edge after reset release valid.

Verification
REQ-039 SHALL cover a basic burst: RAM preloaded mem[k]=k, base=5, len=4, i_ready=1 -> beats 5,6,7,8 on consecutive cycles, o_last on 8, o_done one cycle later, o_busy low after it.
REQ-040 SHALL cover wrap: base=2046, len=4, ARR_DEPTH=2048 -> addresses 2046,2047,0,1 and beats in that order.
REQ-041 SHALL cover backpressure: len=6 with i_ready pattern 1,0,0,1,0,1,1,1... -> exactly beats base..base+5 in order, o_data stable whenever stalled, FIFO never exceeds 2 entries.
REQ-042 SHALL cover zero length: i_start with len=0 -> no o_valid, o_done pulse at the second edge after start, o_busy stays 0.
REQ-043 SHALL cover start while busy: a second i_start during ISSUE with a different base -> ignored; the original burst completes unchanged.
REQ-044 SHALL cover reset mid-burst: i_rst_n low during beat 3 of len=8 -> outputs zero immediately, no beats after release; a new burst base=0, len=2 then yields mem[0], mem[1].
